// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 inverse cipher.
// Byte i of a block sits at bits [127-8*i -: 8], column-major as in FIPS-197.
package aes_pkg;

    localparam int NR      = 10;
    localparam int RK_LAST = 10;

    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADD0  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

    // Row r moves right by r columns: out[r][c] = in[r][(c - r) mod 4].
    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        return {b0, b1, b2, b3};
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = inv_mix_column(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out, table lookup.
module aes_inv_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_o = INV_SBOX[in_i];

endmodule

// File: rtl/aes128_inv_cipher.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched
// from an external store with one cycle of read latency.
module aes128_inv_cipher #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [2:0]   dbg_state_o
);

    // Handshakes: a block moves across in_* or out_* on a rising edge where
    // valid and ready are both high; out_valid/out_data hold until that edge.

    localparam logic [3:0] RK_TOP = 4'(NR);
    localparam logic [3:0] RK_NXT = 4'(NR - 1);

    aes_pkg::state_e fsm_q, fsm_d;
    logic [3:0]      rnd_q, rnd_d;
    aes_pkg::block_t blk_q, blk_d;

    aes_pkg::block_t isr;
    aes_pkg::block_t sub;

    assign isr = aes_pkg::inv_shift_rows(blk_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .in_i  (isr[8 * i +: 8]),
            .out_o (sub[8 * i +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= aes_pkg::ST_IDLE;
            rnd_q <= 4'd0;
            blk_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            rnd_q <= rnd_d;
            blk_q <= blk_d;
        end
    end

    // rk_addr is registered by the store, so each state requests the key the
    // following state consumes.
    always_comb begin
        fsm_d     = fsm_q;
        rnd_d     = rnd_q;
        blk_d     = blk_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_addr   = RK_TOP;
        unique case (fsm_q)
            aes_pkg::ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    blk_d = in_data;
                    fsm_d = aes_pkg::ST_ADD0;
                end
            end
            aes_pkg::ST_ADD0: begin
                rk_addr = RK_NXT;
                blk_d   = blk_q ^ rk_data;
                rnd_d   = RK_NXT;
                fsm_d   = aes_pkg::ST_ROUND;
            end
            aes_pkg::ST_ROUND: begin
                rk_addr = rnd_q - 4'd1;
                blk_d   = aes_pkg::inv_mix_columns(sub ^ rk_data);
                rnd_d   = rnd_q - 4'd1;
                if (rnd_q == 4'd1) begin
                    fsm_d = aes_pkg::ST_FINAL;
                end
            end
            aes_pkg::ST_FINAL: begin
                blk_d = sub ^ rk_data;
                fsm_d = aes_pkg::ST_DONE;
            end
            aes_pkg::ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = aes_pkg::ST_IDLE;
                end
            end
            default: begin
                fsm_d = aes_pkg::ST_IDLE;
            end
        endcase
    end

    assign out_data    = blk_q;
    assign busy        = (fsm_q != aes_pkg::ST_IDLE);
    assign dbg_state_o = fsm_q;

endmodule

// File: doc/aes128_inv_cipher.md
AES128_INV_CIPHER -- requirements
Module: aes128_inv_cipher

Interface
REQ-001 SHALL expose parameter NR, default 10, meaning the number of AES rounds; only 10 (AES-128) is supported.
REQ-002 SHALL expose port: clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL expose port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL expose port: in_valid  input  1  ciphertext block offered.
REQ-005 SHALL expose port: in_ready  output  1  block accepted when in_valid&in_ready.
REQ-006 SHALL expose port: in_data  input  128  ciphertext; bits [127:120] are byte 0; FIPS-197 column-major order.
REQ-007 SHALL expose port: rk_addr  output  4  round-key index for the external key store.
REQ-008 SHALL expose port: rk_data  input  128  round key; valid one cycle after rk_addr is registered by the store.
REQ-009 SHALL expose port: out_valid  output  1  plaintext available.
REQ-010 SHALL expose port: out_ready  input  1  consumer accepts when out_valid&out_ready.
REQ-011 SHALL expose port: out_data  output  128  plaintext, same byte order as in_data.
REQ-012 SHALL expose port: busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, ADD0, ROUND, FINAL and DONE.
REQ-014 IDLE: in_ready=1 and rk_addr=10; on acceptance at cycle T, the block SHALL latch in_data and move to ADD0.
REQ-015 ADD0 (T+1): state <= in_data ^ rk_data (rk[10]); rk_addr=9; the block SHALL move to ROUND with rnd=9.
REQ-016 ROUND (T+2..T+10): state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data); rk_addr=rnd-1; rnd decrements; the block SHALL move to FINAL after the rnd=1 cycle.
REQ-017 FINAL (T+11): state <= InvSubBytes(InvShiftRows(state)) ^ rk_data (rk[0]); the block SHALL move to DONE.
REQ-018 DONE: out_valid=1 from T+12; out_data SHALL equal state and remain stable until out_ready; on handshake the block SHALL move to IDLE; in_ready=0 while in DONE.
REQ-019 Accept-to-out_valid latency SHALL be exactly 12 cycles; throughput SHALL be one block per 13 cycles when out_ready is held high.
REQ-020 in_valid deasserting outside IDLE SHALL have no effect; in_data SHALL be sampled only on the accept edge.
REQ-021 rk_addr SHALL be a pure function of FSM state and rnd, and SHALL never exceed 10.
REQ-022 InvMixColumns SHALL use GF(2^8) with polynomial 0x11B and coefficients {0e,0b,0d,09}; all byte arithmetic SHALL be modulo that polynomial.
REQ-023 When out_ready is already high on the first DONE cycle, the block SHALL complete the handshake in that cycle and be in IDLE with in_ready=1 the cycle after.

Reset
REQ-024 rst=1 SHALL force IDLE, out_valid=0, busy=0, in_ready=1 (after release), rk_addr=10, rnd=0, state=0 and out_data=0 on the next edge.
REQ-025 rst asserted mid-operation SHALL abort the block with no partial out_valid; the first accept after release SHALL behave as from cold reset.

Structure
REQ-026 Package aes_pkg SHALL hold the block_t (128-bit) typedef, the NR and RK_LAST=10 constants, the FSM state enum, and the functions inv_shift_rows, xtime/gf_mul and inv_mix_column.
REQ-027 Sub-module aes_inv_sbox (8-bit in, 8-bit out, combinational) SHALL be instantiated 16 times; no other hierarchy.

Verification
REQ-028 Bench SHALL preload rk[0..10] expanded from key 000102030405060708090a0b0c0d0e0f; in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff, with out_valid exactly 12 cycles after accept.
REQ-029 Bench SHALL preload rk expanded from key 2b7e151628aed2a6abf7158809cf4f3c; in_data=3925841d02dc09fbdc118597196a0b32 -> out_data=3243f6a8885a308d313198a2e0370734.
REQ-030 Bench SHALL hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, and rk_addr=10 throughout.
REQ-031 Bench SHALL assert rst at T+6 of a block -> out_valid never rises; a following REQ-028 block SHALL produce the correct result.
REQ-032 Bench SHALL hold in_valid=1 with out_ready=1 for back-to-back blocks -> accepts exactly 13 cycles apart, and the rk_addr sequence per block SHALL be 10,9,8,...,0,10.
